// File: rtl/bthreadgroup_psum_ctrl.sv
// Partial-sum sequencer and output tile FIFO that sits directly downstream of the
// four-FEDP thread group; feeds partial sums back and buffers finished 4x16-bit tiles.
module bthreadgroup_psum_ctrl #(
    parameter int K_STEPS = 8,
    parameter int DEPTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               result0,
    input  logic [15:0]               result1,
    input  logic [15:0]               result2,
    input  logic [15:0]               result3,
    output logic [15:0]               partial_sum0,
    output logic [15:0]               partial_sum1,
    output logic [15:0]               partial_sum2,
    output logic [15:0]               partial_sum3,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [63:0]               out_data,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [7:0]                step,
    output logic                      ctrl_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0]    LAST_STEP  = 8'(K_STEPS - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic {
        ST_FIRST = 1'b0,
        ST_MID   = 1'b1
    } state_t;

    state_t        r_state;
    logic [7:0]    r_step;
    logic [15:0]   r_psum [4];
    logic [63:0]   r_mem  [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_last;
    logic          w_push;
    logic          w_pop;
    logic          w_first;
    logic [63:0]   w_tile;

    // Both ports are valid/ready: a transfer happens on the rising edge where valid
    // and ready are both high. in_ready depends only on FIFO occupancy (no bypass on
    // a same-cycle pop) and out_valid only on occupancy, so neither side's valid
    // reaches its own ready combinationally; upstream holds data while ready is low.
    assign w_full   = (r_count == FULL_COUNT);
    assign w_empty  = (r_count == '0);
    assign w_accept = in_valid && !w_full;
    assign w_last   = (r_step == LAST_STEP);
    assign w_push   = w_accept && w_last && !clear;
    assign w_pop    = !w_empty && out_ready;
    assign w_tile   = {result3, result2, result1, result0};

    // Step sequencer: a clear abandons the tile in progress, including a step
    // offered in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_FIRST;
            r_step  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                r_psum[i] <= 16'd0;
            end
        end else if (clear) begin
            r_state <= ST_FIRST;
            r_step  <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                r_psum[i] <= 16'd0;
            end
        end else if (w_accept) begin
            r_psum[0] <= result0;
            r_psum[1] <= result1;
            r_psum[2] <= result2;
            r_psum[3] <= result3;
            if (w_last) begin
                r_state <= ST_FIRST;
                r_step  <= 8'd0;
            end else begin
                r_state <= ST_MID;
                r_step  <= r_step + 8'd1;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_tile;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The feedback mux select comes from the state register, so results never
    // reach partial_sum* in the same cycle.
    assign w_first      = (r_state == ST_FIRST);
    assign partial_sum0 = w_first ? 16'd0 : r_psum[0];
    assign partial_sum1 = w_first ? 16'd0 : r_psum[1];
    assign partial_sum2 = w_first ? 16'd0 : r_psum[2];
    assign partial_sum3 = w_first ? 16'd0 : r_psum[3];

    assign in_ready   = !w_full;
    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? 64'd0 : r_mem[r_rptr];
    assign fifo_count = r_count;
    assign step       = r_step;
    assign ctrl_state = r_state;

endmodule

// File: tb/tb_bthreadgroup_psum_ctrl.sv
// Bench for bthreadgroup_psum_ctrl: a K_STEPS=4 and a K_STEPS=1 instance share one
// stimulus stream and are checked every cycle against a queue-based tile model.
module tb_bthreadgroup_psum_ctrl;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] res [4];

  logic        d_in_ready  [2];
  logic [15:0] d_ps        [2][4];
  logic        d_out_valid [2];
  logic [63:0] d_out_data  [2];
  logic [2:0]  d_count     [2];
  logic [7:0]  d_step      [2];
  logic        d_state     [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bthreadgroup_psum_ctrl #(.K_STEPS(4), .DEPTH(DEPTH)) u_dut_k4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_in_ready[0]),
    .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3]),
    .partial_sum0(d_ps[0][0]), .partial_sum1(d_ps[0][1]),
    .partial_sum2(d_ps[0][2]), .partial_sum3(d_ps[0][3]),
    .out_valid(d_out_valid[0]), .out_ready(out_ready), .out_data(d_out_data[0]),
    .fifo_count(d_count[0]), .step(d_step[0]), .ctrl_state(d_state[0])
  );

  bthreadgroup_psum_ctrl #(.K_STEPS(1), .DEPTH(DEPTH)) u_dut_k1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(d_in_ready[1]),
    .result0(res[0]), .result1(res[1]), .result2(res[2]), .result3(res[3]),
    .partial_sum0(d_ps[1][0]), .partial_sum1(d_ps[1][1]),
    .partial_sum2(d_ps[1][2]), .partial_sum3(d_ps[1][3]),
    .out_valid(d_out_valid[1]), .out_ready(out_ready), .out_data(d_out_data[1]),
    .fifo_count(d_count[1]), .step(d_step[1]), .ctrl_state(d_state[1])
  );

  // ---------------- behavioural model ----------------
  int          m_step  [2] = '{0, 0};
  bit          m_first [2] = '{1'b1, 1'b1};
  logic [15:0] m_ps    [2][4];
  logic [63:0] exp_q0 [$];
  logic [63:0] exp_q1 [$];

  function automatic int kst(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int qsize(int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [63:0] qhead(int k);
    if (qsize(k) == 0) return 64'd0;
    return (k == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_step[k]  = 0;
      m_first[k] = 1'b1;
      for (int i = 0; i < 4; i++) m_ps[k][i] = 16'd0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic model_step(int k);
    bit          acc;
    bit          pop;
    logic [63:0] tile;
    acc  = in_valid && (qsize(k) < DEPTH);
    pop  = out_ready && (qsize(k) > 0);
    tile = {res[3], res[2], res[1], res[0]};
    if (pop) begin
      if (k == 0) void'(exp_q0.pop_front());
      else        void'(exp_q1.pop_front());
    end
    if (clear) begin
      m_step[k]  = 0;
      m_first[k] = 1'b1;
      for (int i = 0; i < 4; i++) m_ps[k][i] = 16'd0;
    end else if (acc) begin
      for (int i = 0; i < 4; i++) m_ps[k][i] = res[i];
      if (m_step[k] == kst(k) - 1) begin
        if (k == 0) exp_q0.push_back(tile);
        else        exp_q1.push_back(tile);
        m_step[k]  = 0;
        m_first[k] = 1'b1;
      end else begin
        m_step[k]  = m_step[k] + 1;
        m_first[k] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_dut(int k);
    chk($sformatf("k%0d in_ready", k),   64'(d_in_ready[k]),  64'(qsize(k) < DEPTH));
    chk($sformatf("k%0d out_valid", k),  64'(d_out_valid[k]), 64'(qsize(k) > 0));
    chk($sformatf("k%0d out_data", k),   d_out_data[k],       qhead(k));
    chk($sformatf("k%0d fifo_count", k), 64'(d_count[k]),     64'(qsize(k)));
    chk($sformatf("k%0d step", k),       64'(d_step[k]),      64'(m_step[k]));
    for (int i = 0; i < 4; i++)
      chk($sformatf("k%0d partial_sum%0d", k, i), 64'(d_ps[k][i]),
          m_first[k] ? 64'd0 : 64'(m_ps[k][i]));
  endtask

  always @(negedge clk) begin
    compare_dut(0);
    compare_dut(1);
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(logic [15:0] a, logic [15:0] b, logic [15:0] c, logic [15:0] d);
    res[0] = a; res[1] = b; res[2] = c; res[3] = d;
  endtask

  task automatic set_all(logic [15:0] v);
    set_res(v, v, v, v);
  endtask

  task automatic set_rand();
    set_res(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  logic [63:0] tmp;

  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_all(16'd0);
    tick(); tick();
    chk("rst in_ready", 64'(d_in_ready[0]), 64'd1);
    chk("rst out_valid", 64'(d_out_valid[0]), 64'd0);
    chk("rst out_data", d_out_data[0], 64'd0);
    chk("rst fifo_count", 64'(d_count[0]), 64'd0);
    chk("rst step", 64'(d_step[0]), 64'd0);
    chk("rst partial_sum3", 64'(d_ps[0][3]), 64'd0);
    #2 rst = 1'b1;
    tick();

    // K=4 tile of 10,20,30,40 with downstream always ready
    out_ready = 1'b1; in_valid = 1'b1;
    set_all(16'd10);
    chk("A ps step0", 64'(d_ps[0][0]), 64'd0);
    tick(); chk("A ps step1", 64'(d_ps[0][0]), 64'd10); chk("A step1", 64'(d_step[0]), 64'd1);
    set_all(16'd20);
    tick(); chk("A ps step2", 64'(d_ps[0][1]), 64'd20);
    set_all(16'd30);
    tick(); chk("A ps step3", 64'(d_ps[0][2]), 64'd30); chk("A step3", 64'(d_step[0]), 64'd3);
    set_all(16'd40);
    tick();
    in_valid = 1'b0;
    chk("A out_valid", 64'(d_out_valid[0]), 64'd1);
    chk("A out_data", d_out_data[0], 64'h0028_0028_0028_0028);
    chk("A ps restart", 64'(d_ps[0][0]), 64'd0);
    tick();
    chk("A out_valid drop", 64'(d_out_valid[0]), 64'd0);

    // Negative data passes bit-exact
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (3) begin set_rand(); tick(); end
    set_res(16'h8000, 16'($urandom), 16'($urandom), 16'hFFFF);
    tick();
    in_valid = 1'b0;
    tmp = d_out_data[0];
    chk("neg lane0", 64'(tmp[15:0]), 64'h8000);
    chk("neg lane3", 64'(tmp[63:48]), 64'hFFFF);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("drain k1", 64'(d_count[1]), 64'd0);

    // clear mid-tile with a simultaneous step
    in_valid = 1'b1;
    set_all(16'd5); tick();
    set_all(16'd6); tick();
    chk("clr step2", 64'(d_step[0]), 64'd2);
    set_all(16'd7); clear = 1'b1; tick(); clear = 1'b0;
    chk("clr step", 64'(d_step[0]), 64'd0);
    chk("clr ps", 64'(d_ps[0][0]), 64'd0);
    chk("clr no push", 64'(d_out_valid[0]), 64'd0);
    set_all(16'd1); tick();
    set_all(16'd2); tick();
    set_all(16'd3); tick();
    set_res(16'h000a, 16'h000b, 16'h000c, 16'h000d); tick();
    in_valid = 1'b0;
    chk("clr tile", d_out_data[0], 64'h000d_000c_000b_000a);
    repeat (3) tick();

    // K=1 fill, stall, single pop, pointer wrap
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin set_all(16'h0100 + 16'(i)); tick(); end
    chk("full count", 64'(d_count[1]), 64'd4);
    chk("full in_ready", 64'(d_in_ready[1]), 64'd0);
    set_all(16'h0104);
    tick(); tick();
    chk("full hold", 64'(d_count[1]), 64'd4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pop count", 64'(d_count[1]), 64'd3);
    chk("pop in_ready", 64'(d_in_ready[1]), 64'd1);
    chk("pop head", d_out_data[1], 64'h0101_0101_0101_0101);
    tick();
    chk("refill count", 64'(d_count[1]), 64'd4);
    repeat (30) begin
      set_rand();
      out_ready = ($urandom_range(0, 1) == 1);
      tick();
    end

    // simultaneous push and pop at count 2
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0; in_valid = 1'b1;
    set_all(16'h1111); tick();
    set_all(16'h2222); tick();
    chk("pp count before", 64'(d_count[1]), 64'd2);
    chk("pp head before", d_out_data[1], 64'h1111_1111_1111_1111);
    set_all(16'h3333); out_ready = 1'b1; tick();
    chk("pp count after", 64'(d_count[1]), 64'd2);
    chk("pp head after", d_out_data[1], 64'h2222_2222_2222_2222);

    // async reset between edges with 2 tiles queued and step 3
    in_valid = 1'b0;
    repeat (6) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (11) begin set_rand(); tick(); end
    in_valid = 1'b0;
    chk("ar pre count", 64'(d_count[0]), 64'd2);
    chk("ar pre step", 64'(d_step[0]), 64'd3);
    #2 rst = 1'b0;
    #1;
    chk("ar out_valid", 64'(d_out_valid[0]), 64'd0);
    chk("ar count", 64'(d_count[0]), 64'd0);
    chk("ar step", 64'(d_step[0]), 64'd0);
    chk("ar ps", 64'(d_ps[0][1]), 64'd0);
    chk("ar k1 count", 64'(d_count[1]), 64'd0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    in_valid = 1'b1; set_all(16'h0055);
    tick();
    chk("ar new tile ps", 64'(d_ps[0][0]), 64'h0055);
    chk("ar new tile step", 64'(d_step[0]), 64'd1);

    // randomized traffic
    repeat (1500) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      set_rand();
      tick();
    end
    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bthreadgroup_psum_ctrl.md
# bthreadgroup_psum_ctrl

Partial-sum sequencer and output buffer directly downstream of the four-FEDP thread group. It drives the group's four `partial_sum` inputs, zero on the first reduction step of a tile and the previously captured result on later steps. It captures the group's four signed 16-bit results each step. After `K_STEPS` accepted steps it pushes the finished 4×16-bit output tile into a small FIFO, which drains to writeback over a valid/ready handshake.

## Interface
- `K_STEPS`, default 8: reduction steps per output tile; legal range 1–255.
- `DEPTH`, default 4: output FIFO entries; power of two, at least 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset; clears all state immediately.
- `clear` input 1: synchronous tile abort; step counter and partial-sum registers go to 0; FIFO contents kept.
- `in_valid` input 1: the `result*` inputs hold a valid step result this cycle.
- `in_ready` output 1: step accept; equals `!fifo_full`.
- `result0..result3` input 16 each, signed: thread-group results.
- `partial_sum0..partial_sum3` output 16 each, signed: feed to the thread group.
- `out_valid` output 1: FIFO not empty.
- `out_ready` input 1: downstream accept.
- `out_data` output 64: `{tile3, tile2, tile1, tile0}` at the FIFO head.
- `fifo_count` output $clog2(DEPTH)+1: current occupancy.
- `step` output 8: current step index within the tile.

## Operation
- A step is accepted on `in_valid && in_ready`.
- Step counter `step` counts 0..K_STEPS-1.
- On each accepted step:
  - `psum_reg[i] <= result_i` for all four lanes.
  - If `step == K_STEPS-1`: push `{result3..result0}` into the FIFO, set `step <= 0`, set `first <= 1`.
  - Otherwise: `step <= step+1`, `first <= 0`.
- `partial_sum_i = first ? 0 : psum_reg[i]`. The mux select is registered, so there is no combinational path from `result*` to `partial_sum*`.
- Control states:
  - FIRST (`first=1`, `step=0`) → MID on an accepted step when `K_STEPS>1`.
  - MID → MID while `step<K_STEPS-1`.
  - MID → FIRST on the final accepted step.
  - With `K_STEPS==1`, every accepted step pushes and the block stays in FIRST.
- No arithmetic is done here; all addition happens in the thread group. Data passes bit-exact, with no saturation or extension.
- FIFO behaviour:
  - Pop on `out_valid && out_ready`.
  - Push and pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - `in_ready` is low whenever `fifo_count==DEPTH`, even if a pop occurs that cycle (no bypass). Non-final steps also stall when the FIFO is full.
- `in_valid` while `in_ready=0`: nothing changes; upstream must hold its data.
- `clear`:
  - Takes priority over a simultaneous accepted step; that step is discarded and no push happens.
  - A same-cycle pop still proceeds.
- `in_ready` is a pure function of FIFO state. `in_valid` never feeds `in_ready` combinationally.

## Timing
- Reset values: `partial_sum* = 0`, `step = 0`, `first = 1`, `out_valid = 0`, `out_data = 0`, `fifo_count = 0`, `in_ready = 1`.
- Step accepted at edge t → `partial_sum*` shows that result from t+1 onward.
- Final step accepted at edge t → `out_valid = 1` with that tile on `out_data` in cycle t+1.
- `out_data` at the head is stable while `out_valid && !out_ready`.
- Pop at edge t → next entry (or `out_valid=0`) visible in cycle t+1.
- Reset asserted mid-tile or with a full FIFO → all state, including FIFO contents, is lost asynchronously. The first accepted step after reset starts a new tile with `partial_sum = 0`.

## Test plan
- Reset, then K_STEPS=4, results all lanes 10, 20, 30, 40 on consecutive cycles with `out_ready=1`:
  - `partial_sum` reads 0, 10, 20, 30.
  - One `out_valid` pulse with `out_data = 0x0028_0028_0028_0028` one cycle after the 4th step.
- Negative data: lane0 final result 16'h8000, lane3 16'hFFFF → `out_data[15:0]=16'h8000`, `out_data[63:48]=16'hFFFF`, bit-exact.
- DEPTH=4, `out_ready=0`, K_STEPS=1, `in_valid` held high:
  - `in_ready` drops after exactly 4 accepts; `fifo_count=4`.
  - Raising `out_ready` for 1 cycle pops the first tile; `in_ready` returns the next cycle.
  - Order is preserved across pointer wrap after 10 total tiles.
- `clear` asserted at step 2 of 4 together with `in_valid` → no push; `step=0`; `partial_sum=0` next cycle; a subsequent full tile outputs the correct values.
- `rst` pulsed low asynchronously between clock edges with 2 FIFO entries and step=3 → `out_valid`, `fifo_count`, `step`, `partial_sum` all drop to 0 before the next edge.
- Simultaneous final push and pop at `fifo_count=2` → count stays 2; the head advances to the next entry.
